xdrop_param_loader: RTL and testbench
=====================================

# xdrop_param_loader

Scoring-parameter loader and commit controller for the X-Drop aligner. It accepts the 13 substitution and gap parameters as a word stream over a valid/ready handshake and assembles them in a shadow register. On request, and only while the aligner is idle, it commits the shadow into the active parameter bus. The active bus feeds the nucleotide-to-parameter decoders in every PE, so parameters never change mid-alignment.

## Interface
Parameters:
- PE_WIDTH, 16, bit width of one parameter word (two's complement).
- NUM_PARAMS, 13, number of words per parameter set; fixed at 13.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- cfg_valid  in  1  cfg_data is valid.
- cfg_ready  out  1  loader can accept a word.
- cfg_data  in  PE_WIDTH  parameter word.
- cfg_last  in  1  marks the final word of a set.
- commit_req  in  1  single-cycle request to commit the shadow to active.
- align_busy  in  1  aligner is running; commit is blocked while high.
- commit_done  out  1  one-cycle pulse when the active bus has been updated.
- cfg_error  out  1  one-cycle pulse on a malformed set.
- params_valid  out  1  active_param holds a committed (or default) set.
- active_param  out  13*PE_WIDTH  packed set: {AA, AC, AG, AT, CC, CG, CT, GG, GT, TT, N, gap_open, gap_extend}, with AA in the MSBs.

## Operation
- A beat transfers when cfg_valid && cfg_ready at the clock edge. Word k (0..12) of a set goes to slice [(13-k)*PE_WIDTH-1 : (12-k)*PE_WIDTH] of the shadow.
- FSM states: IDLE, LOAD, FULL, COMMIT_WAIT.
  - IDLE: cfg_ready=1. The first beat writes word 0, sets cnt=1 and moves to LOAD.
  - LOAD: cfg_ready=1. Each beat writes word cnt and increments cnt.
  - A beat at cnt==12 with cfg_last=1 moves to FULL.
  - cfg_last=1 at cnt<12, or cnt==12 with cfg_last=0, is an error: cfg_error pulses, the shadow is discarded (cnt=0) and the FSM returns to IDLE. The active bus is untouched.
  - FULL: cfg_ready=0. On commit_req:
    - if align_busy=0, the shadow is copied to active at that edge and the FSM goes to IDLE;
    - otherwise the FSM goes to COMMIT_WAIT.
  - COMMIT_WAIT: cfg_ready=0. At the first edge with align_busy=0, the shadow is copied to active and the FSM goes to IDLE.
- commit_req in IDLE or LOAD is ignored: no commit, no pulse. commit_req in COMMIT_WAIT is redundant and ignored.
- A single-word set (cfg_last on the first beat in IDLE) is an error.
- Once written, the active bus is stable until the next commit. The shadow is retained after commit but is overwritten by the next load.
- Reset values:
  - state=IDLE, cnt=0, shadow=0.
  - cfg_ready=0 while rst is high.
  - commit_done=0, cfg_error=0.
  - active_param and params_valid: see Configuration.

## Timing
- Load throughput is 1 word/cycle, so the minimum load is 13 cycles; FULL is entered on the edge of beat 13.
- Commit latency: commit_req sampled in FULL with align_busy=0 makes active_param and params_valid update on that edge. commit_done=1 during the following cycle, which is 1 cycle after commit_req.
- With align_busy high, the commit happens on the first edge where align_busy=0, and commit_done follows one cycle later.
- cfg_error is registered: it pulses the cycle after the offending beat.
- All outputs are registered, except cfg_ready, which decodes the state and is gated by rst.
- Reset mid-load or in COMMIT_WAIT drops the pending set: no commit, no pulses.

## Configuration
- Macro: TALCO_PARAM_DEFAULT_EN.
- Defined: reset loads active_param with the default set and drives params_valid=1 from reset.
  - Default set: match (AA, CC, GG, TT) = 2; mismatch = -1; N = -1; gap_open = -3; gap_extend = -1.
  - Values are sign-extended to PE_WIDTH.
- Undefined: reset clears active_param to 0 and params_valid=0 until the first commit.

## Structure
- Shared package talco_pkg holds:
  - the FSM state enum;
  - NUM_PARAMS = 13 and the per-parameter slice index constants (IDX_AA..IDX_GAP_EXT);
  - the default-set constants.
- No sub-module: the FSM, counter, shadow and active registers live in one module, roughly 150–250 lines.

## Test plan
- Load 13 words 0x000D down to 0x0001, then commit_req with align_busy=0 → active_param = {0x000D, ..., 0x0001}; commit_done pulses 1 cycle after the request; params_valid=1.
- Same load with align_busy=1 for 10 cycles after commit_req → active_param is unchanged for those cycles, commits on the first cycle align_busy=0, and commit_done follows one cycle later; cfg_ready=0 throughout.
- cfg_last asserted on word 5 → cfg_error pulses once and cfg_ready=1. A following clean 13-word load then commits correctly; the prior active set is preserved until that commit.
- cfg_valid toggling randomly with 13 beats total → the shadow order is correct and no beat is dropped while cfg_ready=0.
- commit_req in IDLE, and rst asserted after 7 beats → no commit_done. After reset, active_param is 0 with params_valid=0 (macro undefined), or the default set {2,-1,-1,-1,2,-1,-1,2,-1,2,-1,-3,-1} with params_valid=1 (macro defined).

Source files
------------

// File: rtl/talco_pkg.sv
// ----------------------------------------------------------------------------
// talco_pkg
//
// Shared definitions for the X-Drop scoring-parameter loader.
//   - state_e         : loader FSM states
//   - NUM_PARAMS      : words per parameter set (fixed at 13)
//   - IDX_*           : word index of each parameter within a set; word k sits
//                       at slice [(13-k)*W-1 : (12-k)*W] of the packed bus
//   - DEF_*           : power-on default scores (used when
//                       TALCO_PARAM_DEFAULT_EN is defined)
//   - default_word()  : default score for a given word index
// ----------------------------------------------------------------------------
package talco_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StFull,
        StCommitWait
    } state_e;

    localparam int unsigned NUM_PARAMS = 13;

    localparam int unsigned IDX_AA      = 0;
    localparam int unsigned IDX_AC      = 1;
    localparam int unsigned IDX_AG      = 2;
    localparam int unsigned IDX_AT      = 3;
    localparam int unsigned IDX_CC      = 4;
    localparam int unsigned IDX_CG      = 5;
    localparam int unsigned IDX_CT      = 6;
    localparam int unsigned IDX_GG      = 7;
    localparam int unsigned IDX_GT      = 8;
    localparam int unsigned IDX_TT      = 9;
    localparam int unsigned IDX_N       = 10;
    localparam int unsigned IDX_GAP_OPN = 11;
    localparam int unsigned IDX_GAP_EXT = 12;

    localparam int DEF_MATCH    = 2;
    localparam int DEF_MISMATCH = -1;
    localparam int DEF_N        = -1;
    localparam int DEF_GAP_OPEN = -3;
    localparam int DEF_GAP_EXT  = -1;

    // Default score for word index idx; anything not a match, N or gap entry
    // is a mismatch.
    function automatic int default_word(input int unsigned idx);
        int val;
        case (idx)
            IDX_AA, IDX_CC, IDX_GG, IDX_TT: val = DEF_MATCH;
            IDX_N:                          val = DEF_N;
            IDX_GAP_OPN:                    val = DEF_GAP_OPEN;
            IDX_GAP_EXT:                    val = DEF_GAP_EXT;
            default:                        val = DEF_MISMATCH;
        endcase
        return val;
    endfunction

endpackage

// File: rtl/xdrop_param_loader.sv
// ----------------------------------------------------------------------------
// xdrop_param_loader
//
// Collects a 13-word scoring-parameter set over a valid/ready stream into a
// shadow register, then copies it onto the active parameter bus on request,
// but only while the aligner is idle, so PEs never see a mid-run change.
//
// Ports:
//   clk_i           clock, rising edge
//   rst_i           synchronous active-high reset
//   cfg_valid_i     cfg_data_i holds a word
//   cfg_ready_o     loader accepts a word (decoded from state, low in reset)
//   cfg_data_i      parameter word, PE_WIDTH bits, two's complement
//   cfg_last_i      final word of a set
//   commit_req_i    single-cycle request to commit shadow to active
//   align_busy_i    aligner running; commits are held off while high
//   commit_done_o   one-cycle pulse after active bus update
//   cfg_error_o     one-cycle pulse after a malformed set
//   params_valid_o  active bus holds a committed (or default) set
//   active_param_o  {AA,AC,AG,AT,CC,CG,CT,GG,GT,TT,N,gap_open,gap_extend},
//                   AA in the MSBs
//
// Configuration macro: TALCO_PARAM_DEFAULT_EN
//   defined   - reset loads the default score set, params_valid_o=1
//   undefined - reset clears the active bus, params_valid_o=0
// ----------------------------------------------------------------------------
module xdrop_param_loader
    import talco_pkg::*;
#(
    parameter int unsigned PE_WIDTH = 16
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           cfg_valid_i,
    output logic                           cfg_ready_o,
    input  logic [PE_WIDTH-1:0]            cfg_data_i,
    input  logic                           cfg_last_i,
    input  logic                           commit_req_i,
    input  logic                           align_busy_i,
    output logic                           commit_done_o,
    output logic                           cfg_error_o,
    output logic                           params_valid_o,
    output logic [NUM_PARAMS*PE_WIDTH-1:0] active_param_o
);

    localparam int unsigned SetWidth = NUM_PARAMS * PE_WIDTH;
    localparam int unsigned CntW     = $clog2(NUM_PARAMS);
    localparam int unsigned IdxW     = $clog2(SetWidth);
    localparam logic [CntW-1:0] LastIdx = CntW'(NUM_PARAMS - 1);

`ifdef TALCO_PARAM_DEFAULT_EN
    // Truncating the int keeps two's complement, i.e. sign-extends to PE_WIDTH.
    function automatic logic [SetWidth-1:0] default_set();
        logic [SetWidth-1:0] s;
        s = '0;
        for (int k = 0; k < NUM_PARAMS; k++) begin
            s[(NUM_PARAMS-1-k)*PE_WIDTH +: PE_WIDTH] =
                PE_WIDTH'(default_word(int unsigned'(k)));
        end
        return s;
    endfunction

    localparam logic [SetWidth-1:0] RstActive = default_set();
    localparam logic                RstValid  = 1'b1;
`else
    localparam logic [SetWidth-1:0] RstActive = '0;
    localparam logic                RstValid  = 1'b0;
`endif

    state_e                state_q;
    logic [CntW-1:0]       cnt_q;
    logic [SetWidth-1:0]   shadow_q;
    logic [SetWidth-1:0]   active_q;
    logic                  params_valid_q;
    logic                  commit_done_q;
    logic                  cfg_error_q;

    logic                  accepting;
    logic                  beat;
    logic                  commit_fire;
    logic [IdxW-1:0]       word_lsb;

    always_comb begin
        accepting   = (state_q == StIdle) || (state_q == StLoad);
        beat        = cfg_valid_i && accepting && !rst_i;
        // Commit straight from FULL when the aligner is idle, or from
        // COMMIT_WAIT as soon as it goes idle; requests elsewhere are ignored.
        commit_fire = !align_busy_i &&
                      (((state_q == StFull) && commit_req_i) || (state_q == StCommitWait));
        // Word k lands at bit offset (12-k)*PE_WIDTH so word 0 is in the MSBs.
        word_lsb    = IdxW'(32'(LastIdx - cnt_q) * PE_WIDTH);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q        <= StIdle;
            cnt_q          <= '0;
            shadow_q       <= '0;
            active_q       <= RstActive;
            params_valid_q <= RstValid;
            commit_done_q  <= 1'b0;
            cfg_error_q    <= 1'b0;
        end else begin
            commit_done_q <= 1'b0;
            cfg_error_q   <= 1'b0;

            unique case (state_q)
                StIdle, StLoad: begin
                    if (beat) begin
                        shadow_q[word_lsb +: PE_WIDTH] <= cfg_data_i;
                        if (cnt_q == LastIdx) begin
                            cnt_q <= '0;
                            if (cfg_last_i) begin
                                state_q <= StFull;
                            end else begin
                                state_q     <= StIdle;
                                cfg_error_q <= 1'b1;
                            end
                        end else if (cfg_last_i) begin
                            // Short set (including a single word): drop it.
                            cnt_q       <= '0;
                            state_q     <= StIdle;
                            cfg_error_q <= 1'b1;
                        end else begin
                            cnt_q   <= cnt_q + CntW'(1);
                            state_q <= StLoad;
                        end
                    end
                end

                StFull: begin
                    if (commit_fire) begin
                        active_q       <= shadow_q;
                        params_valid_q <= 1'b1;
                        commit_done_q  <= 1'b1;
                        state_q        <= StIdle;
                    end else if (commit_req_i) begin
                        state_q <= StCommitWait;
                    end
                end

                StCommitWait: begin
                    if (commit_fire) begin
                        active_q       <= shadow_q;
                        params_valid_q <= 1'b1;
                        commit_done_q  <= 1'b1;
                        state_q        <= StIdle;
                    end
                end

                default: begin
                    state_q <= StIdle;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign cfg_ready_o    = !rst_i && accepting;
    assign commit_done_o  = commit_done_q;
    assign cfg_error_o    = cfg_error_q;
    assign params_valid_o = params_valid_q;
    assign active_param_o = active_q;

endmodule

// File: tb/tb_xdrop_param_loader.sv
// Bench for xdrop_param_loader: expected active sets are queued when a commit
// is requested and popped when commit_done is observed.
module tb_xdrop_param_loader;

    localparam int NP = 13;
    localparam int W  = 16;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            cfg_valid = 1'b0;
    logic            cfg_ready;
    logic [W-1:0]    cfg_data = '0;
    logic            cfg_last = 1'b0;
    logic            commit_req = 1'b0;
    logic            align_busy = 1'b0;
    logic            commit_done;
    logic            cfg_error;
    logic            params_valid;
    logic [NP*W-1:0] active_param;

    xdrop_param_loader #(
        .PE_WIDTH(W)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .cfg_valid_i    (cfg_valid),
        .cfg_ready_o    (cfg_ready),
        .cfg_data_i     (cfg_data),
        .cfg_last_i     (cfg_last),
        .commit_req_i   (commit_req),
        .align_busy_i   (align_busy),
        .commit_done_o  (commit_done),
        .cfg_error_o    (cfg_error),
        .params_valid_o (params_valid),
        .active_param_o (active_param)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int err_cnt = 0;

    logic [NP*W-1:0] exp_q[$];
    logic [NP*W-1:0] cur_active;
    logic [NP*W-1:0] rst_exp;
    logic            rst_pv;
    logic [NP*W-1:0] got;
    logic [W-1:0]    words[NP];

    always @(posedge clk) begin
        #1;
        if (commit_done === 1'b1) done_cnt++;
        if (cfg_error === 1'b1) err_cnt++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [NP*W-1:0] pack_words();
        logic [NP*W-1:0] s;
        s = '0;
        for (int k = 0; k < NP; k++) s[(NP-1-k)*W +: W] = words[k];
        return s;
    endfunction

    // Sends words[0..n-1]; cfg_last on the final one if last_final.
    task automatic load_words(input int n, input bit last_final, input bit rand_gap);
        bit ready_seen;
        int guard;
        for (int k = 0; k < n; k++) begin
            if (rand_gap) begin
                repeat ($urandom_range(0, 3)) begin
                    cfg_valid = 1'b0;
                    cfg_data  = 16'hBAD0;
                    step();
                end
            end
            cfg_valid = 1'b1;
            cfg_data  = words[k];
            cfg_last  = last_final && (k == n - 1);
            ready_seen = 1'b0;
            guard = 0;
            while (!ready_seen) begin
                ready_seen = cfg_ready;
                step();
                guard++;
                if (!ready_seen && guard > 50) begin
                    checks++;
                    errors++;
                    $display("FAIL ready_timeout beat %0d got ready=%b want 1", k, cfg_ready);
                    break;
                end
            end
        end
        cfg_valid = 1'b0;
        cfg_last  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        checks++;
        if (cfg_ready !== 1'b0) begin
            errors++; $display("FAIL rst_ready got %b want 0", cfg_ready);
        end
        step();
        rst = 1'b0;
        #1;
        checks++;
        if (cfg_ready !== 1'b1) begin
            errors++; $display("FAIL idle_ready got %b want 1", cfg_ready);
        end
        checks++;
        if (active_param !== rst_exp) begin
            errors++; $display("FAIL rst_active got %h want %h", active_param, rst_exp);
        end
        checks++;
        if (params_valid !== rst_pv) begin
            errors++; $display("FAIL rst_pvalid got %b want %b", params_valid, rst_pv);
        end
        checks++;
        if (commit_done !== 1'b0 || cfg_error !== 1'b0) begin
            errors++;
            $display("FAIL rst_pulses got done=%b err=%b want 0 0", commit_done, cfg_error);
        end
        cur_active = rst_exp;
    endtask

    task automatic test_basic_commit();
        for (int k = 0; k < NP; k++) words[k] = W'(13 - k);
        load_words(NP, 1'b1, 1'b0);
        checks++;
        if (cfg_ready !== 1'b0) begin
            errors++; $display("FAIL full_ready got %b want 0", cfg_ready);
        end
        exp_q.push_back(pack_words());
        commit_req = 1'b1;
        step();
        commit_req = 1'b0;
        got = exp_q.pop_front();
        checks++;
        if (active_param !== got) begin
            errors++; $display("FAIL basic_active got %h want %h", active_param, got);
        end
        checks++;
        if (commit_done !== 1'b1) begin
            errors++; $display("FAIL basic_done got %b want 1", commit_done);
        end
        checks++;
        if (params_valid !== 1'b1) begin
            errors++; $display("FAIL basic_pvalid got %b want 1", params_valid);
        end
        cur_active = got;
        step();
        checks++;
        if (commit_done !== 1'b0 || cfg_ready !== 1'b1) begin
            errors++;
            $display("FAIL basic_after got done=%b ready=%b want 0 1", commit_done, cfg_ready);
        end
    endtask

    task automatic test_busy_commit();
        for (int k = 0; k < NP; k++) words[k] = 16'h0100 + W'(k);
        load_words(NP, 1'b1, 1'b0);
        exp_q.push_back(pack_words());
        align_busy = 1'b1;
        commit_req = 1'b1;
        step();
        commit_req = 1'b0;
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (active_param !== cur_active || commit_done !== 1'b0 || cfg_ready !== 1'b0) begin
                errors++;
                $display("FAIL busy_hold cyc %0d got act=%h done=%b rdy=%b want act=%h done=0 rdy=0",
                         i, active_param, commit_done, cfg_ready, cur_active);
            end
            commit_req = (i == 3);
            step();
        end
        commit_req = 1'b0;
        align_busy = 1'b0;
        step();
        got = exp_q.pop_front();
        checks++;
        if (active_param !== got || commit_done !== 1'b1) begin
            errors++;
            $display("FAIL busy_commit got act=%h done=%b want act=%h done=1",
                     active_param, commit_done, got);
        end
        cur_active = got;
        step();
        checks++;
        if (commit_done !== 1'b0 || cfg_ready !== 1'b1) begin
            errors++;
            $display("FAIL busy_after got done=%b ready=%b want 0 1", commit_done, cfg_ready);
        end
    endtask

    task automatic test_error();
        int lens[3] = '{1, 5, 13};
        bit lasts[3] = '{1'b1, 1'b1, 1'b0};
        int e0;
        for (int c = 0; c < 3; c++) begin
            for (int k = 0; k < NP; k++) words[k] = 16'hE000 + W'(c * 16 + k);
            e0 = err_cnt;
            load_words(lens[c], lasts[c], 1'b0);
            checks++;
            if (cfg_error !== 1'b1 || cfg_ready !== 1'b1) begin
                errors++;
                $display("FAIL err_pulse len %0d got err=%b rdy=%b want 1 1",
                         lens[c], cfg_error, cfg_ready);
            end
            step();
            checks++;
            if (cfg_error !== 1'b0 || err_cnt - e0 != 1) begin
                errors++;
                $display("FAIL err_once len %0d got err=%b pulses=%0d want 0 1",
                         lens[c], cfg_error, err_cnt - e0);
            end
            checks++;
            if (active_param !== cur_active) begin
                errors++;
                $display("FAIL err_active len %0d got %h want %h", lens[c], active_param, cur_active);
            end
        end
        for (int k = 0; k < NP; k++) words[k] = 16'h2000 + W'(k * 3);
        load_words(NP, 1'b1, 1'b0);
        checks++;
        if (active_param !== cur_active) begin
            errors++; $display("FAIL err_preserve got %h want %h", active_param, cur_active);
        end
        exp_q.push_back(pack_words());
        commit_req = 1'b1;
        step();
        commit_req = 1'b0;
        got = exp_q.pop_front();
        checks++;
        if (active_param !== got || commit_done !== 1'b1) begin
            errors++;
            $display("FAIL err_recover got act=%h done=%b want act=%h done=1",
                     active_param, commit_done, got);
        end
        cur_active = got;
        step();
    endtask

    task automatic test_random_valid();
        for (int k = 0; k < NP; k++) words[k] = W'($urandom);
        load_words(NP, 1'b1, 1'b1);
        // Offer junk while FULL; none of it may be taken.
        cfg_valid = 1'b1;
        cfg_data  = 16'hDEAD;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (cfg_ready !== 1'b0) begin
                errors++; $display("FAIL rand_full_ready cyc %0d got %b want 0", i, cfg_ready);
            end
            step();
        end
        cfg_valid = 1'b0;
        exp_q.push_back(pack_words());
        commit_req = 1'b1;
        step();
        commit_req = 1'b0;
        got = exp_q.pop_front();
        checks++;
        if (active_param !== got || commit_done !== 1'b1) begin
            errors++;
            $display("FAIL rand_commit got act=%h done=%b want act=%h done=1",
                     active_param, commit_done, got);
        end
        cur_active = got;
        step();
    endtask

    task automatic test_idle_commit_reset();
        int d0;
        int e0;
        d0 = done_cnt;
        e0 = err_cnt;
        commit_req = 1'b1;
        step();
        commit_req = 1'b0;
        step();
        step();
        checks++;
        if (done_cnt != d0 || active_param !== cur_active) begin
            errors++;
            $display("FAIL idle_commit got pulses=%0d act=%h want 0 act=%h",
                     done_cnt - d0, active_param, cur_active);
        end
        for (int k = 0; k < NP; k++) words[k] = 16'h3000 + W'(k);
        load_words(7, 1'b0, 1'b0);
        rst = 1'b1;
        commit_req = 1'b1;
        step();
        commit_req = 1'b0;
        step();
        rst = 1'b0;
        step();
        step();
        checks++;
        if (done_cnt != d0 || err_cnt != e0) begin
            errors++;
            $display("FAIL rst_mid_pulses got done=%0d err=%0d want 0 0",
                     done_cnt - d0, err_cnt - e0);
        end
        checks++;
        if (active_param !== rst_exp || params_valid !== rst_pv) begin
            errors++;
            $display("FAIL rst_mid_state got act=%h pv=%b want act=%h pv=%b",
                     active_param, params_valid, rst_exp, rst_pv);
        end
        cur_active = rst_exp;
        // A load right after reset must start again at word 0.
        for (int k = 0; k < NP; k++) words[k] = 16'h4000 + W'(k * 7);
        load_words(NP, 1'b1, 1'b0);
        exp_q.push_back(pack_words());
        commit_req = 1'b1;
        step();
        commit_req = 1'b0;
        got = exp_q.pop_front();
        checks++;
        if (active_param !== got || params_valid !== 1'b1) begin
            errors++;
            $display("FAIL post_rst_commit got act=%h pv=%b want act=%h pv=1",
                     active_param, params_valid, got);
        end
        cur_active = got;
        step();
    endtask

    initial begin
        int dflt[NP] = '{2, -1, -1, -1, 2, -1, -1, 2, -1, 2, -1, -3, -1};
`ifdef TALCO_PARAM_DEFAULT_EN
        for (int k = 0; k < NP; k++) rst_exp[(NP-1-k)*W +: W] = W'(dflt[k]);
        rst_pv = 1'b1;
`else
        rst_exp = '0;
        rst_pv  = 1'b0;
        if (dflt[0] != 2) $display("note: default table unexpected");
`endif
        test_reset();
        test_basic_commit();
        test_busy_commit();
        test_error();
        test_random_valid();
        test_idle_commit_reset();
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL scoreboard_left got %0d want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
